mux_4_1: RTL and testbench

- Four-input, WIDTH-bit word multiplexer: a 2-bit select picks one of d0..d3.
- Provides two copies of the selected word:
  - y: combinational, zero latency.
  - y_q: registered, one cycle latency, with a valid flag.
- Sits in datapath steering logic. Consumers that need same-cycle data use y; timing-critical consumers use y_q.

---
 rtl/mux_4_1.sv | 65 ++++++
 tb/tb_mux_4_1.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mux_4_1.sv
// mux_4_1: four-input WIDTH-bit word multiplexer.
// y is the zero-latency selected word. y_q/out_valid are a registered copy
// that updates only when the inputs are qualified by in_valid.
module mux_4_1 #(
  parameter int unsigned           WIDTH       = 4,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid
);

  // Data words gathered into an array so that the select becomes a plain
  // index. Indexing with an unknown sel yields X in simulation instead of
  // silently falling back to one of the inputs.
  logic [WIDTH-1:0] words [4];

  assign words[0] = d0;
  assign words[1] = d1;
  assign words[2] = d2;
  assign words[3] = d3;

  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] y_q_reg;
  logic [WIDTH-1:0] y_q_next;
  logic             out_valid_reg;
  logic             out_valid_next;

  // Selected word, shared by the combinational output and the capture path.
  assign sel_word = words[sel];
  assign y        = sel_word;

  // Next-state: capture on in_valid, otherwise hold the word and drop valid.
  always_comb begin
    y_q_next       = y_q_reg;
    out_valid_next = 1'b0;
    if (in_valid) begin
      y_q_next       = sel_word;
      out_valid_next = 1'b1;
    end
  end

  // Output register; reset wins over a simultaneous in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_reg       <= RESET_VALUE;
      out_valid_reg <= 1'b0;
    end else begin
      y_q_reg       <= y_q_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign y_q       = y_q_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_4_1.sv
// tb_mux_4_1: directed scenarios followed by randomized cycles, all checked
// against a clocked behavioural reference kept in the bench.
module tb_mux_4_1;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] d0, d1, d2, d3;
  logic [1:0]   sel;
  logic         in_valid;
  logic [W-1:0] y;
  logic [W-1:0] y_q;
  logic         out_valid;

  int vectors;
  int miscompares;

  // Reference state for the registered path.
  logic [W-1:0] exp_yq;
  logic         exp_ov;

  mux_4_1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .sel       (sel),
    .in_valid  (in_valid),
    .y         (y),
    .y_q       (y_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference selection: shift the packed word bundle by sel words.
  function automatic logic [W-1:0] ref_pick(input logic [W-1:0] a0, a1, a2, a3,
                                            input logic [1:0] s);
    logic [4*W-1:0] bundle;
    bundle = {a3, a2, a1, a0};
    return W'(bundle >> (int'(s) * W));
  endfunction

  // Reference register behaviour, sampling the pre-edge inputs.
  always @(posedge clk) begin
    if (rst) begin
      exp_yq <= '0;
      exp_ov <= 1'b0;
    end else if (in_valid) begin
      exp_yq <= ref_pick(d0, d1, d2, d3, sel);
      exp_ov <= 1'b1;
    end else begin
      exp_ov <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [W-1:0] a0, a1, a2, a3, input logic [1:0] s);
    d0 = a0; d1 = a1; d2 = a2; d3 = a3; sel = s;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b1;
    set_d(4'h0, 4'h0, 4'h0, 4'hF, 2'b11);

    // Reset held for two edges with valid data pending.
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_yq", y_q, 4'h0);
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_y", y, 4'hF);
    end

    // Combinational select sweep (reset still held).
    set_d(4'b0001, 4'b0010, 4'b0100, 4'b1000, 2'b00); #1; chk("sweep_00", y, 4'b0001);
    set_d(4'b0000, 4'b0011, 4'b0100, 4'b1000, 2'b01); #1; chk("sweep_01", y, 4'b0011);
    set_d(4'b0000, 4'b0000, 4'b0111, 4'b1000, 2'b10); #1; chk("sweep_10", y, 4'b0111);
    set_d(4'b0000, 4'b0000, 4'b0000, 4'b1111, 2'b11); #1; chk("sweep_11", y, 4'b1111);
    set_d(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00); #1; chk("all_zero", y, 4'b0000);

    // Release reset and capture 1111.
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    set_d(4'h0, 4'h0, 4'h0, 4'hF, 2'b11);
    cycle();
    chk("cap_yq", y_q, 4'hF);
    chk("cap_ov", out_valid, 1'b1);

    // Data change without sel change: y follows at once, y_q waits.
    in_valid = 1'b0;
    set_d(4'h0, 4'b0011, 4'h0, 4'h0, 2'b01); #1;
    chk("dchg_y0", y, 4'b0011);
    d1 = 4'b1010; #1;
    chk("dchg_y1", y, 4'b1010);
    chk("dchg_yq", y_q, 4'hF);

    // Valid gating: hold word, drop valid.
    set_d(4'b0101, 4'h0, 4'h0, 4'h0, 2'b00);
    cycle();
    chk("gate_yq", y_q, 4'hF);
    chk("gate_ov", out_valid, 1'b0);
    chk("gate_y", y, 4'b0101);
    in_valid = 1'b1;
    cycle();
    chk("regate_yq", y_q, 4'b0101);
    chk("regate_ov", out_valid, 1'b1);

    // Reset beats valid on the same edge.
    rst = 1'b1;
    in_valid = 1'b1;
    set_d(4'hA, 4'hB, 4'hC, 4'hD, 2'b10);
    cycle();
    chk("prio_yq", y_q, 4'h0);
    chk("prio_ov", out_valid, 1'b0);
    rst = 1'b0;

    // Randomized cycles against the reference model.
    for (int i = 0; i < 300; i++) begin
      rst      = ($urandom_range(0, 19) == 0);
      in_valid = $urandom_range(0, 1);
      set_d(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom));
      #1;
      chk("rnd_y", y, ref_pick(d0, d1, d2, d3, sel));
      cycle();
      chk("rnd_yq", y_q, exp_yq);
      chk("rnd_ov", out_valid, exp_ov);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
